i2c_reg_arbiter: RTL and testbench

Shared register file and access arbiter behind the I2C slave engine. Two requesters, the I2C slave datapath and a local host port, read and write a DEPTH-entry register bank through identical req/ack handshakes. The block serialises the accesses, holds the read-only device-ID register at address 0 and flags out-of-range addresses.

---
 rtl/i2c_reg_arbiter_if.sv | 36 +++
 rtl/i2c_reg_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_reg_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_arbiter_if.sv
// Request/response bundle between the I2C slave datapath, the local host port
// and the register arbiter. Requesters use the master modport, the arbiter uses slave.
interface i2c_reg_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              i2c_req;
    logic              i2c_we;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata;
    logic              i2c_ack;
    logic [DATA_W-1:0] i2c_rdata;
    logic              i2c_err;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_err;

    modport master (
        output i2c_req, i2c_we, i2c_addr, i2c_wdata,
        input  i2c_ack, i2c_rdata, i2c_err,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_err
    );

    modport slave (
        input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
        output i2c_ack, i2c_rdata, i2c_err,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_err
    );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// Two-port register bank arbiter: I2C datapath and local host share DEPTH registers.
// Define I2C_ARB_RR_EN for round-robin arbitration; default is fixed I2C priority.
module i2c_reg_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int DEV_ID = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    i2c_reg_arbiter_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        ACCESS = 3'b010,
        ACK    = 3'b100
    } state_t;

    state_t            r_state;
    logic              r_sel_host;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_bank [DEPTH];

    logic              r_i2c_ack,   r_host_ack;
    logic              r_i2c_err,   r_host_err;
    logic [DATA_W-1:0] r_i2c_rdata, r_host_rdata;

    logic              w_pick_host;
    logic              w_oor;
    logic              w_zero;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd;

`ifdef I2C_ARB_RR_EN
    logic r_last_host;
    // On a tie the port that did not win last time goes first.
    assign w_pick_host = bus.host_req && (!bus.i2c_req || !r_last_host);
`else
    assign w_pick_host = bus.host_req && !bus.i2c_req;
`endif

    assign w_oor  = 32'(r_addr) >= 32'(DEPTH);
    assign w_zero = (r_addr == '0);
    assign w_idx  = r_addr[IDX_W-1:0];
    assign w_rd   = w_oor  ? '0 :
                    w_zero ? DATA_W'(DEV_ID) : r_bank[w_idx];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_sel_host   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i2c_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_i2c_err    <= 1'b0;
            r_host_err   <= 1'b0;
            r_i2c_rdata  <= '0;
            r_host_rdata <= '0;
`ifdef I2C_ARB_RR_EN
            r_last_host  <= 1'b1;
`endif
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i2c_req || bus.host_req) begin
                        r_sel_host <= w_pick_host;
                        r_we       <= w_pick_host ? bus.host_we    : bus.i2c_we;
                        r_addr     <= w_pick_host ? bus.host_addr  : bus.i2c_addr;
                        r_wdata    <= w_pick_host ? bus.host_wdata : bus.i2c_wdata;
`ifdef I2C_ARB_RR_EN
                        r_last_host <= w_pick_host;
`endif
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_we && !w_oor && !w_zero) r_bank[w_idx] <= r_wdata;
                    // Writes also refresh rdata with the pre-write contents.
                    if (r_sel_host) begin
                        r_host_ack   <= 1'b1;
                        r_host_rdata <= w_rd;
                        r_host_err   <= w_oor;
                    end else begin
                        r_i2c_ack    <= 1'b1;
                        r_i2c_rdata  <= w_rd;
                        r_i2c_err    <= w_oor;
                    end
                    r_state <= ACK;
                end
                ACK: begin
                    r_i2c_ack  <= 1'b0;
                    r_host_ack <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i2c_ack    = r_i2c_ack;
    assign bus.i2c_rdata  = r_i2c_rdata;
    assign bus.i2c_err    = r_i2c_err;
    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.host_err   = r_host_err;
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter: handshake latency, ID register, range errors,
// arbitration ties, starvation behaviour and reset abort.
module tb_i2c_reg_arbiter;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    i2c_reg_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    i2c_reg_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .DEV_ID(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on one port; ack expected on the 2nd edge after req is sampled.
    task automatic xact(input string tag, input bit host, input bit we,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input bit chk_rd, input logic [7:0] exp_rd, input bit exp_err);
        int lat;
        logic [7:0] rd;
        logic er, other;
        lat = 0; rd = 'x; er = 'x; other = 'x;
        @(posedge CLK); #1;
        if (host) begin
            bus.host_req = 1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
        end else begin
            bus.i2c_req = 1; bus.i2c_we = we; bus.i2c_addr = addr; bus.i2c_wdata = wdata;
        end
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(posedge CLK); #1;
            if (host ? bus.host_ack : bus.i2c_ack) begin
                lat   = c;
                rd    = host ? bus.host_rdata : bus.i2c_rdata;
                er    = host ? bus.host_err   : bus.i2c_err;
                other = host ? bus.i2c_ack    : bus.host_ack;
            end
        end
        bus.i2c_req = 0;
        bus.host_req = 0;
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_err"}, er, exp_err);
        chk({tag, "_other_ack"}, other, 0);
        if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
        @(posedge CLK); #1;
        chk({tag, "_ack_drop"}, host ? bus.host_ack : bus.i2c_ack, 0);
    endtask

    initial begin
        int ti, th, ni, nh, alt_bad, both, prev, hgot;
        logic [7:0] hrd;
        bus.i2c_req = 0; bus.i2c_we = 0; bus.i2c_addr = '0; bus.i2c_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_i2c_ack", bus.i2c_ack, 0);
        chk("rst_host_ack", bus.host_ack, 0);
        chk("rst_i2c_rdata", bus.i2c_rdata, 0);
        chk("rst_host_rdata", bus.host_rdata, 0);
        chk("rst_i2c_err", bus.i2c_err, 0);
        chk("rst_host_err", bus.host_err, 0);
        RST_N = 1;

        // I2C write/read
        xact("i2c_wr3", 0, 1, 8'd3, 8'hA5, 0, 8'h00, 0);
        xact("i2c_rd3", 0, 0, 8'd3, 8'h00, 1, 8'hA5, 0);

        // ID register
        xact("host_wr0", 1, 1, 8'd0, 8'hFF, 0, 8'h00, 0);
        xact("host_rd0", 1, 0, 8'd0, 8'h00, 1, 8'h05, 0);
        chk("i2c_rdata_hold", bus.i2c_rdata, 8'hA5);

        // Out of range
        xact("i2c_wr16", 0, 1, 8'd16, 8'h11, 0, 8'h00, 1);
        xact("i2c_rd16", 0, 0, 8'd16, 8'h00, 1, 8'h00, 1);
        xact("i2c_rd3b", 0, 0, 8'd3, 8'h00, 1, 8'hA5, 0);
        xact("i2c_rd15", 0, 0, 8'd15, 8'h00, 1, 8'h00, 0);

        // Simultaneous requests: I2C writes 0x22 to 5, host reads 5
        ti = 0; th = 0; hrd = 'x;
        @(posedge CLK); #1;
        bus.i2c_req = 1; bus.i2c_we = 1; bus.i2c_addr = 8'd5; bus.i2c_wdata = 8'h22;
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'd5;
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLK); #1;
            if (bus.i2c_ack && ti == 0) begin ti = c; bus.i2c_req = 0; end
            if (bus.host_ack && th == 0) begin th = c; hrd = bus.host_rdata; bus.host_req = 0; end
        end
`ifdef I2C_ARB_RR_EN
        chk("sim_host_lat", th, 2);
        chk("sim_i2c_lat", ti, 5);
        chk("sim_host_rdata", hrd, 8'h00);
`else
        chk("sim_i2c_lat", ti, 2);
        chk("sim_host_lat", th, 5);
        chk("sim_host_rdata", hrd, 8'h22);
`endif

        // Starvation: both ports hold req high for 30 cycles
        ni = 0; nh = 0; alt_bad = 0; both = 0; prev = 2;
        @(posedge CLK); #1;
        bus.i2c_req = 1; bus.i2c_we = 0; bus.i2c_addr = 8'd3;
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'd5;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            if (bus.i2c_ack && bus.host_ack) both++;
            if (bus.i2c_ack) begin ni++; if (prev == 0) alt_bad++; prev = 0; end
            if (bus.host_ack) begin nh++; if (prev == 1) alt_bad++; prev = 1; end
        end
        bus.i2c_req = 0;
        chk("starve_total", ni + nh, 10);
        chk("starve_both", both, 0);
`ifdef I2C_ARB_RR_EN
        chk("starve_host_acks", nh, 5);
        chk("starve_alternate", alt_bad, 0);
`else
        chk("starve_host_acks", nh, 0);
`endif
        chk("starve_i2c_rdata", bus.i2c_rdata, 8'hA5);
        hgot = 0; hrd = 'x;
        for (int c = 0; c < 10 && hgot == 0; c++) begin
            @(posedge CLK); #1;
            if (bus.host_ack) begin hgot = 1; hrd = bus.host_rdata; end
        end
        bus.host_req = 0;
        chk("starve_host_served", hgot, 1);
        chk("starve_host_rdata", hrd, 8'h22);
        repeat (3) @(posedge CLK);

        // Reset mid-ACCESS during host write of 0x3C to addr 4
        @(posedge CLK); #1;
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'd4; bus.host_wdata = 8'h3C;
        @(posedge CLK); #1;
        RST_N = 0;
        #1;
        chk("abort_i2c_ack", bus.i2c_ack, 0);
        chk("abort_host_ack", bus.host_ack, 0);
        chk("abort_i2c_rdata", bus.i2c_rdata, 0);
        chk("abort_host_rdata", bus.host_rdata, 0);
        chk("abort_i2c_err", bus.i2c_err, 0);
        chk("abort_host_err", bus.host_err, 0);
        bus.host_req = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
        hgot = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (bus.host_ack || bus.i2c_ack) hgot++;
        end
        chk("abort_no_ack", hgot, 0);
        xact("post_rst_rd4", 1, 0, 8'd4, 8'h00, 1, 8'h00, 0);
        xact("post_rst_rd3", 0, 0, 8'd3, 8'h00, 1, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
